// File: rtl/booth_r8_mac.sv
// booth_r8_mac: iterative radix-8 Booth multiply-accumulate with valid/ready handshakes
module booth_r8_mac #(
  parameter int WIDTH = 16,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [1:0]           sign_mode,
  input  logic                 acc_en,
  input  logic                 acc_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow,
  output logic                 busy
);
  localparam int N = (WIDTH+3)/3;
  localparam int EW = 3*N;
  localparam int H = EW+3;
  localparam int PW = 2*WIDTH+1;
  localparam int CW = $clog2(N+1);
  typedef enum logic [1:0] {IDLE, RUN, ACCUM, HOLD} state_t;
  state_t state, state_nx;
  logic [H-1:0] a_r, a3_r, hi, a_x, sel, sum;
  logic [EW:0] lo;
  logic [EW-1:0] b_x;
  logic [2:0] t, mag;
  logic neg, ae_r, as_r, ovf, ov_new;
  logic [CW-1:0] cnt;
  logic [ACC_WIDTH-1:0] acc, p_ext, addend, acc_sum;
  assign a_x = {{(H-WIDTH){sign_mode[1] & multiplicand[WIDTH-1]}}, multiplicand};
  assign b_x = {{(EW-WIDTH){sign_mode[0] & multiplier[WIDTH-1]}}, multiplier};
  always_comb begin
    t = {1'b0, lo[2], 1'b0} + {2'b0, lo[1]} + {2'b0, lo[0]};
    mag = lo[3] ? 3'd4 - t : t;
    neg = lo[3] & (t != 3'd4);
    sel = mag == 3'd1 ? a_r : mag == 3'd2 ? {a_r[H-2:0], 1'b0} : mag == 3'd3 ? a3_r : mag == 3'd4 ? {a_r[H-3:0], 2'b0} : '0;
    sum = hi + (neg ? ~sel : sel) + {{(H-1){1'b0}}, neg};
    p_ext = ACC_WIDTH'($signed(PW'({hi, lo[EW:1]})));
    addend = as_r ? ~p_ext : p_ext;
    acc_sum = acc + addend + {{(ACC_WIDTH-1){1'b0}}, as_r};
    ov_new = (acc[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) && (acc_sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? RUN : IDLE;
      RUN:     state_nx = cnt == CW'(1) ? ACCUM : RUN;
      ACCUM:   state_nx = HOLD;
      default: state_nx = out_ready ? IDLE : HOLD;
    endcase
    in_ready = state == IDLE;
    busy = state != IDLE;
    out_valid = state == HOLD;
    result = acc;
    overflow = ovf;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        a_r <= a_x;
        a3_r <= a_x + {a_x[H-2:0], 1'b0};
        hi <= '0;
        lo <= {b_x, 1'b0};
        cnt <= CW'(N);
        ae_r <= acc_en;
        as_r <= acc_sub;
      end
      if (state == RUN) begin
        {hi, lo} <= {{3{sum[H-1]}}, sum, lo[EW:3]};
        cnt <= cnt - 1'b1;
      end
      if (state == ACCUM) begin
        acc <= ae_r ? acc_sum : p_ext;
        ovf <= ae_r & (ovf | ov_new);
      end
    end
  end
endmodule

// File: tb/tb_booth_r8_mac.sv
// tb_booth_r8_mac: randomized scoreboard bench for booth_r8_mac
module tb_booth_r8_mac;
  localparam int W = 16;
  localparam int AW = 40;
  localparam int N = (W+3)/3;
  typedef struct {logic [AW-1:0] res; logic ov; int cyc;} exp_t;
  logic clk = 0, rst = 1, rst2 = 1;
  logic in_valid = 0, in_ready, acc_en = 0, acc_sub = 0, out_valid, out_ready = 0, overflow, busy;
  logic [W-1:0] a = 0, b = 0;
  logic [1:0] sm = 0;
  logic [AW-1:0] result;
  logic in_valid2 = 0, in_ready2, acc_en2 = 0, acc_sub2 = 0, out_valid2, out_ready2 = 0, overflow2, busy2;
  logic [W-1:0] a2 = 0, b2 = 0;
  logic [1:0] sm2 = 0;
  logic [32:0] result2;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0, cyc = 0, last_acc = 0, or_mode = 1, bp = 0;
  bit ov_prev = 0, chk_idle = 0, r;
  logic [AW-1:0] held;
  logic signed [AW-1:0] m_acc = 0;
  logic m_ov = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  booth_r8_mac #(.WIDTH(W), .ACC_WIDTH(AW)) dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(a), .multiplier(b), .sign_mode(sm), .acc_en(acc_en), .acc_sub(acc_sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .overflow(overflow), .busy(busy));
  booth_r8_mac #(.WIDTH(W), .ACC_WIDTH(33)) dut2 (.clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
    .multiplicand(a2), .multiplier(b2), .sign_mode(sm2), .acc_en(acc_en2), .acc_sub(acc_sub2), .out_valid(out_valid2),
    .out_ready(out_ready2), .result(result2), .overflow(overflow2), .busy(busy2));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic model(input logic [W-1:0] a_i, b_i, input logic [1:0] sm_i, input logic ae_i, as_i);
    longint pa, pb, p, ex, lim;
    lim = longint'(1) << (AW-1);
    pa = sm_i[1] ? longint'($signed(a_i)) : longint'(a_i);
    pb = sm_i[0] ? longint'($signed(b_i)) : longint'(b_i);
    p = pa * pb;
    if (!ae_i) begin
      m_acc = p[AW-1:0];
      m_ov = 0;
    end else begin
      ex = longint'(m_acc) + (as_i ? -p : p);
      if (ex >= lim || ex < -lim) m_ov = 1;
      m_acc = ex[AW-1:0];
    end
  endtask
  task automatic issue(input logic [W-1:0] a_i, b_i, input logic [1:0] sm_i, input logic ae_i, as_i,
                       input bit use_c = 0, input logic [AW-1:0] c_res = '0, input logic c_ov = 0);
    int t = 0;
    bit took;
    in_valid = 1; a = a_i; b = b_i; sm = sm_i; acc_en = ae_i; acc_sub = as_i;
    do begin
      took = in_ready;
      @(posedge clk); #1;
      t++;
    end while (!took && t < 200);
    in_valid = 0;
    chk("accept", took, 1);
    if (took) begin
      model(a_i, b_i, sm_i, ae_i, as_i);
      q.push_back('{use_c ? c_res : m_acc, use_c ? c_ov : m_ov, cyc});
      last_acc = cyc;
    end
  endtask
  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || busy) && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", q.size() == 0 && !busy, 1);
    chk("idle_result", result, m_acc);
  endtask
  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    v = W'($urandom);
    case ($urandom_range(0, 7))
      0: v = 16'h8000;
      1: v = 16'hFFFF;
      2: v = 16'h0000;
      3: v = 16'h7FFF;
      default: ;
    endcase
    return v;
  endfunction
  task automatic op2(input logic [W-1:0] a_i, b_i, input logic [1:0] sm_i, input logic ae_i, as_i,
                     input logic [32:0] er, input logic eo);
    int t = 0;
    bit took;
    in_valid2 = 1; a2 = a_i; b2 = b_i; sm2 = sm_i; acc_en2 = ae_i; acc_sub2 = as_i;
    do begin
      took = in_ready2;
      @(posedge clk); #1;
      t++;
    end while (!took && t < 50);
    in_valid2 = 0;
    t = 0;
    while (!out_valid2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("acc33_result", result2, er);
    chk("acc33_overflow", overflow2, eo);
    out_ready2 = 1;
    @(posedge clk); #1;
    out_ready2 = 0;
  endtask
  always begin
    @(posedge clk); #1;
    if (rst) ov_prev = 0;
    else begin
      if (chk_idle) begin
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        chk_idle = 0;
      end
      r = (or_mode == 0) ? ($urandom_range(0, 2) != 0) : (or_mode == 1);
      if (out_valid) begin
        chk("hold_in_ready", in_ready, 0);
        if (!ov_prev) begin
          bp = 0;
          held = result;
          chk("pending", q.size() != 0, 1);
          if (q.size() != 0) chk("latency", cyc - q[0].cyc + 1, N + 2);
        end else chk("hold_stable", result, held);
        if (or_mode == 2) r = bp >= 5;
        bp++;
        if (r && q.size() != 0) begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("overflow", overflow, e.ov);
          chk_idle = or_mode == 2;
        end
      end
      out_ready = r;
      ov_prev = out_valid;
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int prev;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst2_result", result2, 0);
    rst = 0; rst2 = 0;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    or_mode = 1;
    issue(16'hFFFF, 16'hFFFF, 2'b00, 0, 0, 1, 40'h00_FFFE_0001, 0);
    issue(16'h8000, 16'h8000, 2'b11, 0, 0, 1, 40'h00_4000_0000, 0);
    issue(16'hFFFF, 16'hFFFF, 2'b10, 0, 0, 1, 40'hFF_FFFF_0001, 0);
    issue(16'd100, 16'd200, 2'b11, 0, 0, 1, 40'd20000, 0);
    issue(16'd3, 16'hFFF9, 2'b11, 1, 0, 1, 40'd19979, 0);
    issue(16'd10, 16'd10, 2'b11, 1, 1, 1, 40'h4DA7, 0);
    drain();
    for (int i = 0; i < 6; i++) begin
      prev = last_acc;
      issue(pick(), pick(), 2'($urandom), 1'($urandom), 1'($urandom));
      if (i > 0) chk("throughput", last_acc - prev, N + 3);
    end
    or_mode = 0;
    for (int i = 0; i < 300; i++)
      issue(pick(), pick(), 2'($urandom), $urandom_range(0, 3) != 0, 1'($urandom));
    drain();
    or_mode = 2;
    issue(16'h1234, 16'h0042, 2'b00, 0, 0);
    for (int t = 0; t < 50 && !out_valid; t++) begin
      @(posedge clk); #1;
    end
    chk("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      in_valid = (i % 2) == 0;
      @(posedge clk); #1;
    end
    in_valid = 0;
    drain();
    or_mode = 1;
    issue(16'd1234, 16'd77, 2'b11, 0, 0);
    drain();
    issue(16'd999, 16'd55, 2'b11, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_overflow", overflow, 0);
    rst = 0;
    q.delete();
    m_acc = 0; m_ov = 0;
    @(posedge clk); #1;
    chk("abort_in_ready", in_ready, 1);
    op2(16'hFFFF, 16'hFFFF, 2'b00, 0, 0, 33'd4294836225, 0);
    op2(16'hFFFF, 16'hFFFF, 2'b00, 1, 0, 33'h1_FFFC_0002, 1);
    op2(16'hFFFF, 16'hFFFF, 2'b00, 1, 0, 33'h0_FFFA_0003, 1);
    op2(16'd3, 16'd5, 2'b00, 0, 0, 33'd15, 0);
    op2(16'hFFFF, 16'hFFFF, 2'b00, 1, 0, 33'h0_FFFE_0010, 0);
    op2(16'hFFFF, 16'hFFFF, 2'b00, 1, 0, 33'h1_FFFC_0011, 1);
    in_valid2 = 1; a2 = 16'd7; b2 = 16'd9; sm2 = 2'b00; acc_en2 = 1;
    @(posedge clk); #1;
    in_valid2 = 0;
    @(posedge clk); #1;
    chk("acc33_run_busy", busy2, 1);
    rst2 = 1;
    @(posedge clk); #1;
    chk("acc33_abort_out_valid", out_valid2, 0);
    chk("acc33_abort_busy", busy2, 0);
    chk("acc33_abort_result", result2, 0);
    chk("acc33_abort_overflow", overflow2, 0);
    rst2 = 0;
    @(posedge clk); #1;
    chk("acc33_abort_in_ready", in_ready2, 1);
    repeat (12) @(posedge clk);
    #1;
    chk("acc33_no_stale_output", out_valid2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/booth_r8_mac.md
Name: booth_r8_mac

Overview:
- Parametrised iterative radix-8 Booth multiply-accumulate unit. Successor to the fixed 8/16-bit sequential Booth multipliers.
- Accepts WIDTH-bit operands with independent per-operand signedness. Retires one Booth digit per cycle.
- Multiplies, or accumulates/subtracts the product into an ACC_WIDTH-bit accumulator. Reports sticky signed overflow.
- Valid/ready handshakes on input and output, so it can sit behind or before stalling DSP-datapath stages.

Parameters:
- WIDTH, 16, operand width; legal range 4..32.
- ACC_WIDTH, 2*WIDTH+8, accumulator/result width; must be >= 2*WIDTH+1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand/command valid.
- in_ready  out  1  block can accept; high only in IDLE.
- multiplicand  in  WIDTH  operand A.
- multiplier  in  WIDTH  operand B.
- sign_mode  in  2  [1]=A signed, [0]=B signed.
- acc_en  in  1  0: load product into accumulator; 1: accumulate.
- acc_sub  in  1  with acc_en=1: subtract product instead of add; ignored when acc_en=0.
- out_valid  out  1  result valid, held until accepted.
- out_ready  in  1  downstream accepts result.
- result  out  ACC_WIDTH  accumulator value (two's complement).
- overflow  out  1  sticky signed-overflow flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset state: IDLE, accumulator=0, result=0, overflow=0, out_valid=0, busy=0. in_ready=1 from the first cycle after rst deasserts.
- rst asserted in any state (including mid-RUN or HOLD) aborts the operation and discards the pending result.
- Iterations: N = ceil((WIDTH+1)/3). WIDTH=16 gives N=6; WIDTH=8 gives N=3.
- Operand extension: each operand is extended to 3N bits. Use sign extension if its sign_mode bit is set, zero extension otherwise.
- States: IDLE, RUN, ACCUM, HOLD.
- IDLE:
  - Accept when in_valid && in_ready.
  - On the accepting edge, register: extended A, 3A (computed from inputs), B with an appended 0 LSB, acc_en, acc_sub. Load the digit counter with N. Go to RUN.
- RUN:
  - Each cycle, decode 4 LSBs of the product shift register into a digit in {-4..+4}.
  - Select 0/A/2A/3A/4A; negate via invert plus carry-in.
  - Add to the upper partial sum. Arithmetic-shift the register right by 3.
  - After N cycles go to ACCUM.
- ACCUM:
  - Sign-extend the 2*WIDTH+1-bit product to ACC_WIDTH.
  - acc_en=0: acc <= P, overflow <= 0.
  - acc_en=1, acc_sub=0: acc <= acc+P.
  - acc_en=1, acc_sub=1: acc <= acc-P.
  - On add/sub, set overflow if the signed ACC_WIDTH result wraps (operand signs equal, result sign differs). Never clear it here. Result wraps modulo 2^ACC_WIDTH.
  - Go to HOLD.
- HOLD:
  - out_valid=1; result and overflow stable.
  - On out_ready, go to IDLE on the next edge and drop out_valid.
  - in_valid is ignored outside IDLE.
- Latency: out_valid rises N+2 cycles after the accepting edge (8 for WIDTH=16).
- Throughput: at best one operation per N+3 cycles, with out_ready held high.
- in_ready is combinational from state only, with no dependency on in_valid.
- result always equals the accumulator, including while in IDLE.
- No combinational path from in_valid or out_ready to any output except through state.
- Extreme values:
  - -2^(W-1) × -2^(W-1) (both signed) = 2^(2W-2), exact.
  - Unsigned max × max = (2^W-1)^2, exact.
- Holding out_ready high continuously is legal.
- Holding in_valid high continuously causes back-to-back accepts each time IDLE is reached.

Test Plan (WIDTH=16, ACC_WIDTH=40 unless stated):
- Unsigned max: A=0xFFFF, B=0xFFFF, sign_mode=00, acc_en=0 -> result=0x00_FFFE_0001, overflow=0. out_valid exactly 8 cycles after accept.
- Signed min: A=0x8000, B=0x8000, sign_mode=11 -> result=0x00_4000_0000.
- Mixed: A=0xFFFF (signed, -1), B=0xFFFF (unsigned 65535), sign_mode=10 -> result=0xFF_FFFF_0001.
- MAC sequence, sign_mode=11:
  - Load 100×200 -> 20000.
  - Then acc_en=1: 3×(-7) -> 19979.
  - Then acc_en=1, acc_sub=1: 10×10 -> 19879 (0x4DA7).
- Back-pressure: hold out_ready=0 for 5 cycles in HOLD while pulsing in_valid -> result stable, in_ready=0, no accept. Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Overflow and reset (ACC_WIDTH=33):
  - 0xFFFF×0xFFFF unsigned load -> 4294836225, overflow=0.
  - Repeat with acc_en=1 -> result=-262142, overflow=1.
  - Next load (acc_en=0) clears overflow.
  - Assert rst during RUN -> next cycle out_valid=0, busy=0, result=0, overflow=0, in_ready=1 after release.
